// File: rtl/pin_irq_pkg.sv
// Shared types and defaults for the pin interrupt arbiter.
`ifndef NUM_PINS
`define NUM_PINS 24
`endif

package pin_irq_pkg;

  localparam int NUM_PINS_DEF     = `NUM_PINS;
  localparam int ID_W_DEF         = (NUM_PINS_DEF > 1) ? $clog2(NUM_PINS_DEF) : 1;
  localparam int DROP_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CLR  = 2'd2,
    S_DROP = 2'd3
  } state_e;

  // Keeps the drop counter at least one bit wide for tiny timeouts.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/pin_irq_prio_enc.sv
// Combinational lowest-index-wins encoder over the masked pending vector.
module pin_irq_prio_enc #(
  parameter int NUM_SRC = 24,
  parameter int ID_W    = 5
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    idx,
  output logic               vld
);

  always_comb begin
    idx = '0;
    vld = |req;
    // Scanning downward leaves the lowest set index as the final assignment.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/pin_irq_ctrl.sv
// Masks per-pin interrupt levels, presents the lowest pending index to the core
// via REQ/ACK, pulses IRQRES on acknowledge, then waits (bounded) for the line to drop.
module pin_irq_ctrl
  import pin_irq_pkg::*;
#(
  parameter int NUM_SRC      = `NUM_PINS,
  parameter int ID_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int DROP_TIMEOUT = DROP_TIMEOUT_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] INTR,
  input  logic [NUM_SRC-1:0] IRQ_MASK,
  input  logic               IRQ_ACK,
  input  logic               ERR_CLR,
  output logic [NUM_SRC-1:0] IRQRES,
  output logic               IRQ_REQ,
  output logic [ID_W-1:0]    IRQ_ID,
  output logic [NUM_SRC-1:0] IRQ_PENDING,
  output logic               IRQ_ERR
);

  localparam int               CNT_W    = cnt_width(DROP_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DROP_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] intr_q, intr_d;
  logic [NUM_SRC-1:0] irqres_q, irqres_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_req_q, irq_req_d;
  logic               err_q, err_d;

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] id_bit;
  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic               timeout;

  assign pending = intr_q & IRQ_MASK;
  assign id_bit  = NUM_SRC'(1) << id_q;

  pin_irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req (pending),
    .idx (win_id),
    .vld (win_vld)
  );

  always_comb begin
    intr_d  = INTR;
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          id_d    = win_id;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // An acknowledge beats a same-cycle withdrawal.
        if (IRQ_ACK) begin
          state_d = S_CLR;
        end else if (!(|(pending & id_bit))) begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        state_d = S_DROP;
      end
      S_DROP: begin
        // Unmasked level is checked here so a mask change cannot abort the drop wait.
        if (!(|(intr_q & id_bit))) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    irq_req_d = (state_d == S_REQ);
    irqres_d  = (state_d == S_CLR) ? (NUM_SRC'(1) << id_d) : '0;
    err_d     = (err_q & ~ERR_CLR) | timeout;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      intr_q    <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      irq_req_q <= 1'b0;
      irqres_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      intr_q    <= intr_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      irq_req_q <= irq_req_d;
      irqres_q  <= irqres_d;
      err_q     <= err_d;
    end
  end

  assign IRQ_REQ     = irq_req_q;
  assign IRQ_ID      = id_q;
  assign IRQRES      = irqres_q;
  assign IRQ_PENDING = pending;
  assign IRQ_ERR     = err_q;

endmodule

// File: tb/tb_pin_irq_ctrl.sv
// Directed and randomized checks of pin_irq_ctrl against a transaction-level priority model.
module tb_pin_irq_ctrl;

  localparam int NS = 24;
  localparam int IW = 5;
  localparam logic [NS-1:0] ALL = {NS{1'b1}};

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [NS-1:0] INTR;
  logic [NS-1:0] IRQ_MASK;
  logic          IRQ_ACK;
  logic          ERR_CLR;
  logic [NS-1:0] IRQRES;
  logic          IRQ_REQ;
  logic [IW-1:0] IRQ_ID;
  logic [NS-1:0] IRQ_PENDING;
  logic          IRQ_ERR;

  int checks = 0;
  int errors = 0;

  pin_irq_ctrl #(
    .NUM_SRC      (NS),
    .ID_W         (IW),
    .DROP_TIMEOUT (16)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .INTR        (INTR),
    .IRQ_MASK    (IRQ_MASK),
    .IRQ_ACK     (IRQ_ACK),
    .ERR_CLR     (ERR_CLR),
    .IRQRES      (IRQRES),
    .IRQ_REQ     (IRQ_REQ),
    .IRQ_ID      (IRQ_ID),
    .IRQ_PENDING (IRQ_PENDING),
    .IRQ_ERR     (IRQ_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!IRQ_REQ && n < budget) begin
      tick();
      n++;
    end
    check("req_seen", {31'd0, IRQ_REQ}, 32'd1);
  endtask

  // Lowest set index via isolating the least significant one.
  function automatic int lowest(input logic [NS-1:0] v);
    logic [NS-1:0] iso;
    iso = v & (~v + 1'b1);
    return $clog2(iso);
  endfunction

  // One complete service: request seen, ID checked, ACK, single IRQRES pulse, line dropped.
  task automatic serve(input int exp_id);
    logic [NS-1:0] bit_v;
    bit_v = '0;
    bit_v[exp_id] = 1'b1;
    wait_req(40);
    check("serve_id", {27'd0, IRQ_ID}, exp_id);
    check("serve_pending", {8'd0, IRQ_PENDING}, {8'd0, INTR & IRQ_MASK});
    IRQ_ACK = 1'b1;
    tick();
    check("serve_irqres", {8'd0, IRQRES}, {8'd0, bit_v});
    check("serve_req_low", {31'd0, IRQ_REQ}, 32'd0);
    IRQ_ACK = 1'b0;
    INTR[exp_id] = 1'b0;
    tick();
    check("serve_irqres_end", {8'd0, IRQRES}, 32'd0);
  endtask

  initial begin
    logic [NS-1:0] v, m, b;

    RST_N = 1'b0; INTR = '0; IRQ_MASK = ALL; IRQ_ACK = 1'b0; ERR_CLR = 1'b0;
    tick(); tick();
    check("rst_req", {31'd0, IRQ_REQ}, 32'd0);
    check("rst_id", {27'd0, IRQ_ID}, 32'd0);
    check("rst_irqres", {8'd0, IRQRES}, 32'd0);
    check("rst_pending", {8'd0, IRQ_PENDING}, 32'd0);
    check("rst_err", {31'd0, IRQ_ERR}, 32'd0);
    RST_N = 1'b1;
    tick();

    // Single source latency and pulse width.
    INTR = 24'h000020;
    tick();
    check("t1_pending", {8'd0, IRQ_PENDING}, 32'h20);
    check("t1_req_early", {31'd0, IRQ_REQ}, 32'd0);
    tick();
    check("t1_req", {31'd0, IRQ_REQ}, 32'd1);
    check("t1_id", {27'd0, IRQ_ID}, 32'd5);
    IRQ_ACK = 1'b1;
    tick();
    check("t1_irqres", {8'd0, IRQRES}, 32'h20);
    IRQ_ACK = 1'b0;
    tick();
    check("t1_irqres_one", {8'd0, IRQRES}, 32'd0);
    INTR = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_idle", {31'd0, IRQ_REQ}, 32'd0);
    end

    // Simultaneous sources served in index order.
    INTR = 24'h800104;
    serve(2);
    serve(8);
    serve(23);
    repeat (3) tick();
    check("t2_idle", {31'd0, IRQ_REQ}, 32'd0);

    // Withdrawal by masking, then ACK racing the mask.
    INTR = 24'h000008;
    wait_req(10);
    check("t3_id", {27'd0, IRQ_ID}, 32'd3);
    IRQ_MASK = ~24'h000008;
    tick();
    check("t3_withdraw", {31'd0, IRQ_REQ}, 32'd0);
    check("t3_no_res", {8'd0, IRQRES}, 32'd0);
    tick();
    check("t3_stay_idle", {31'd0, IRQ_REQ}, 32'd0);
    check("t3_no_res2", {8'd0, IRQRES}, 32'd0);
    IRQ_MASK = ALL;
    wait_req(10);
    check("t3_id2", {27'd0, IRQ_ID}, 32'd3);
    IRQ_MASK = ~24'h000008;
    IRQ_ACK = 1'b1;
    tick();
    check("t3_ack_wins", {8'd0, IRQRES}, 32'h8);
    IRQ_ACK = 1'b0; IRQ_MASK = ALL; INTR = '0;
    repeat (4) tick();
    check("t3_idle", {31'd0, IRQ_REQ}, 32'd0);

    // Stuck source: timeout, re-request, sticky error with clear race.
    INTR = 24'h000080;
    wait_req(10);
    check("t4_id", {27'd0, IRQ_ID}, 32'd7);
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    repeat (16) tick();
    check("t4_err_before", {31'd0, IRQ_ERR}, 32'd0);
    tick();
    check("t4_err_set", {31'd0, IRQ_ERR}, 32'd1);
    check("t4_req_low", {31'd0, IRQ_REQ}, 32'd0);
    tick();
    check("t4_rereq", {31'd0, IRQ_REQ}, 32'd1);
    check("t4_rereq_id", {27'd0, IRQ_ID}, 32'd7);
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    repeat (16) tick();
    check("t4_err_held", {31'd0, IRQ_ERR}, 32'd1);
    ERR_CLR = 1'b1;
    tick();
    check("t4_set_beats_clr", {31'd0, IRQ_ERR}, 32'd1);
    ERR_CLR = 1'b0;
    tick();
    check("t4_rereq2", {31'd0, IRQ_REQ}, 32'd1);
    ERR_CLR = 1'b1;
    tick();
    check("t4_err_clr", {31'd0, IRQ_ERR}, 32'd0);
    ERR_CLR = 1'b0; INTR = '0;
    repeat (4) tick();
    check("t4_idle", {31'd0, IRQ_REQ}, 32'd0);

    // Reset during CLR cuts the pulse; the held line is re-arbitrated.
    INTR = 24'h000002;
    wait_req(10);
    IRQ_ACK = 1'b1;
    tick();
    check("t5_irqres", {8'd0, IRQRES}, 32'h2);
    IRQ_ACK = 1'b0; RST_N = 1'b0;
    tick();
    check("t5_rst_res", {8'd0, IRQRES}, 32'd0);
    check("t5_rst_req", {31'd0, IRQ_REQ}, 32'd0);
    check("t5_rst_pend", {8'd0, IRQ_PENDING}, 32'd0);
    RST_N = 1'b1;
    tick();
    check("t5_rel_req", {31'd0, IRQ_REQ}, 32'd0);
    tick();
    check("t5_rereq", {31'd0, IRQ_REQ}, 32'd1);
    check("t5_rereq_id", {27'd0, IRQ_ID}, 32'd1);
    serve(1);
    repeat (3) tick();

    // ACK with nothing pending is ignored.
    IRQ_ACK = 1'b1;
    tick();
    check("t6_res", {8'd0, IRQRES}, 32'd0);
    check("t6_req", {31'd0, IRQ_REQ}, 32'd0);
    IRQ_ACK = 1'b0;
    tick();
    check("t6_res2", {8'd0, IRQRES}, 32'd0);
    check("t6_req2", {31'd0, IRQ_REQ}, 32'd0);

    // Random source/mask sets drained in model order.
    for (int it = 0; it < 20; it++) begin
      v = NS'($urandom);
      m = NS'($urandom);
      b = '0;
      b[$urandom_range(NS - 1, 0)] = 1'b1;
      v = v | b;
      m = m | b;
      IRQ_MASK = m;
      INTR = v;
      while ((INTR & IRQ_MASK) != '0) begin
        serve(lowest(INTR & IRQ_MASK));
      end
      INTR = '0;
      IRQ_MASK = ALL;
      repeat (4) tick();
      check("rand_idle", {31'd0, IRQ_REQ}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
